// File: rtl/conv_run_sequencer_pkg.sv
// Shared types and constants for the binary convolution run sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, SRAM widths, header limits, header range helper.
package conv_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int DIM_W  = 5;
  localparam int KERN_W = 9;

  localparam logic [DATA_W-1:0] TERM_WORD = 16'h00FF;
  localparam int MIN_DIM = 3;
  localparam int MAX_DIM = 16;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    HDR_REQ,
    HDR_CHK,
    ROW_REQ,
    ROW_HOLD,
    WAIT_DP,
    DRAIN
  } seq_state_t;

  // A header starts a matrix only when it is a legal dimension; anything
  // else (including TERM_WORD) ends the run.
  function automatic logic hdr_is_dim(input logic [DATA_W-1:0] w);
    return (w != TERM_WORD) &&
           (w >= DATA_W'(MIN_DIM)) &&
           (w <= DATA_W'(MAX_DIM));
  endfunction

endpackage

// File: rtl/conv_run_sequencer_if.sv
// Bundle of run handshake, SRAM ports and datapath stream for the sequencer.
// Latency: n/a (wires only).
// Backpressure: rows use dp_row_valid/dp_row_ready; results are never stalled.
// master = sequencer side, slave = SRAMs + datapath + host side.
interface conv_run_sequencer_if;
  import conv_pkg::*;

  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [DATA_W-1:0] sram_dut_read_data;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [DATA_W-1:0] wmem_dut_read_data;
  logic              dut_sram_write_enable;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic [DATA_W-1:0] dut_sram_write_data;
  logic              dp_start;
  logic [DIM_W-1:0]  dp_dim;
  logic [KERN_W-1:0] dp_kernel;
  logic              dp_row_valid;
  logic [DATA_W-1:0] dp_row_data;
  logic              dp_row_ready;
  logic              dp_res_valid;
  logic [DATA_W-1:0] dp_res_data;
  logic              dp_done;

  modport master (
    input  dut_run, sram_dut_read_data, wmem_dut_read_data,
           dp_row_ready, dp_res_valid, dp_res_data, dp_done,
    output dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data,
           dp_start, dp_dim, dp_kernel, dp_row_valid, dp_row_data
  );

  modport slave (
    output dut_run, sram_dut_read_data, wmem_dut_read_data,
           dp_row_ready, dp_res_valid, dp_res_data, dp_done,
    input  dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_enable, dut_sram_write_address, dut_sram_write_data,
           dp_start, dp_dim, dp_kernel, dp_row_valid, dp_row_data
  );

endinterface

// File: rtl/conv_run_sequencer_result_writer.sv
// Registers datapath results into sequential output SRAM writes.
// Latency: 1 cycle from res_vld to wr_en.
// Backpressure: none; accepts a result every cycle.
// Ports: clr_ptr restarts at address 0; res_vld/res_dat in; wr_en/wr_addr/wr_dat to SRAM.
module conv_result_writer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              clr_ptr,
  input  logic              res_vld,
  input  logic [DATA_W-1:0] res_dat,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_dat
);

  logic [ADDR_W-1:0] out_ptr_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      out_ptr_q <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_dat    <= '0;
    end else begin
      wr_en <= res_vld;
      if (clr_ptr) begin
        out_ptr_q <= '0;
      end else if (res_vld) begin
        wr_addr   <= out_ptr_q;
        wr_dat    <= res_dat;
        // Wraps 4095 -> 0 by width.
        out_ptr_q <= out_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_run_sequencer.sv
// Run sequencer: loads kernel, walks input SRAM headers/rows, streams rows, logs results.
// Latency: row issued 2 cycles after its request; result written 1 cycle after dp_res_valid.
// Backpressure: rows held stable until dp_row_ready; results are never stalled.
// Ports: clk, reset_b (async, active low), bus (master side of conv_run_sequencer_if).
module conv_run_sequencer
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_b,
  conv_run_sequencer_if.master bus
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] in_ptr_q;
  logic [DIM_W-1:0]  row_cnt_q;
  logic [DIM_W-1:0]  row_cnt_nxt;
  logic [DIM_W-1:0]  dim_q;
  logic [KERN_W-1:0] kernel_q;
  logic              start_q;
  logic              row_held_q;
  logic [DATA_W-1:0] row_dat_q;
  logic              run_acc;
  logic              hdr_ok;
  logic              res_en;
  logic              unused_wmem_hi;

  assign run_acc     = (state_q == IDLE) && bus.dut_run;
  assign hdr_ok      = hdr_is_dim(bus.sram_dut_read_data);
  assign res_en      = (state_q != IDLE) && bus.dp_res_valid;
  assign row_cnt_nxt = row_cnt_q + 1'b1;
  assign unused_wmem_hi = ^bus.wmem_dut_read_data[DATA_W-1:KERN_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.dut_run) state_d = WLOAD;
      WLOAD:    state_d = HDR_REQ;
      HDR_REQ:  state_d = HDR_CHK;
      HDR_CHK:  state_d = hdr_ok ? ROW_REQ : DRAIN;
      ROW_REQ:  state_d = ROW_HOLD;
      ROW_HOLD: if (bus.dp_row_ready) state_d = (row_cnt_nxt == dim_q) ? WAIT_DP : ROW_REQ;
      WAIT_DP:  if (bus.dp_done) state_d = HDR_REQ;
      // A result arriving now is written next cycle, so stay until none is in flight.
      DRAIN:    if (!bus.dp_res_valid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q    <= IDLE;
      in_ptr_q   <= '0;
      row_cnt_q  <= '0;
      dim_q      <= '0;
      kernel_q   <= '0;
      start_q    <= 1'b0;
      row_held_q <= 1'b0;
      row_dat_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= 1'b0;
      case (state_q)
        WLOAD: begin
          kernel_q <= bus.wmem_dut_read_data[KERN_W-1:0];
          in_ptr_q <= '0;
        end
        HDR_CHK: begin
          if (hdr_ok) begin
            dim_q     <= bus.sram_dut_read_data[DIM_W-1:0];
            start_q   <= 1'b1;
            row_cnt_q <= '0;
            in_ptr_q  <= in_ptr_q + 1'b1;
          end
        end
        ROW_HOLD: begin
          if (bus.dp_row_ready) begin
            row_held_q <= 1'b0;
            in_ptr_q   <= in_ptr_q + 1'b1;
            row_cnt_q  <= row_cnt_nxt;
          end else if (!row_held_q) begin
            // Capture the row on the first stalled cycle so it stays stable
            // whatever the SRAM read port does afterwards.
            row_held_q <= 1'b1;
            row_dat_q  <= bus.sram_dut_read_data;
          end
        end
        default: ;
      endcase
    end
  end

  // First ROW_HOLD cycle forwards the SRAM word directly, giving one row per 2 cycles.
  assign bus.dp_row_data  = (state_q != ROW_HOLD) ? '0 :
                            (row_held_q ? row_dat_q : bus.sram_dut_read_data);
  assign bus.dp_row_valid = (state_q == ROW_HOLD);
  assign bus.dut_busy     = (state_q != IDLE);
  assign bus.dut_sram_read_address = in_ptr_q;
  assign bus.dut_wmem_read_address = '0;
  assign bus.dp_start     = start_q;
  assign bus.dp_dim       = dim_q;
  assign bus.dp_kernel    = kernel_q;

  conv_result_writer u_writer (
    .clk     (clk),
    .reset_b (reset_b),
    .clr_ptr (run_acc),
    .res_vld (res_en),
    .res_dat (bus.dp_res_data),
    .wr_en   (bus.dut_sram_write_enable),
    .wr_addr (bus.dut_sram_write_address),
    .wr_dat  (bus.dut_sram_write_data)
  );

endmodule

// File: tb/tb_conv_run_sequencer.sv
// Directed bench for conv_run_sequencer with SRAM and datapath models.
// Latency: n/a.
// Backpressure: datapath model stalls dp_row_ready by stall_cfg cycles per row.
module tb_conv_run_sequencer;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset_b;
  always #5 clk = ~clk;

  conv_run_sequencer_if bus();
  conv_run_sequencer dut (.clk(clk), .reset_b(reset_b), .bus(bus));

  logic [DATA_W-1:0] imem [0:4095];
  logic [DATA_W-1:0] wmem [0:4095];

  // Synchronous-read SRAM models: data one cycle after address.
  always @(posedge clk) begin
    bus.sram_dut_read_data <= imem[bus.dut_sram_read_address];
    bus.wmem_dut_read_data <= wmem[bus.dut_wmem_read_address];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                c;
  } wr_t;

  wr_t               wr_q[$];
  logic [DATA_W-1:0] rx_q[$];
  logic [ADDR_W-1:0] rx_addr_q[$];
  int                dim_log[$];
  int                start_cnt = 0;
  int                res_idx = 0;
  int                stall_cfg = 0;
  int                res_n_ovr = 0;
  int                fall_cyc = 0;

  // Output SRAM write log.
  always @(negedge clk) begin
    wr_t w;
    if (reset_b === 1'b1 && bus.dut_sram_write_enable === 1'b1) begin
      w.a = bus.dut_sram_write_address;
      w.d = bus.dut_sram_write_data;
      w.c = cyc;
      wr_q.push_back(w);
    end
  end

  // Datapath model: accept dim rows, then emit (dim-2)^2 results (or res_n_ovr),
  // dp_done on the last one. Result data is 0x8000 + running index.
  initial begin : dp_model
    int mode, mdim, mrows, left, stall;
    bit seen;
    logic [DATA_W-1:0] first_dat;
    logic [ADDR_W-1:0] first_addr;
    bus.dp_row_ready = 1'b0;
    bus.dp_res_valid = 1'b0;
    bus.dp_res_data  = '0;
    bus.dp_done      = 1'b0;
    mode = 0; mdim = 0; mrows = 0; left = 0; stall = 0; seen = 1'b0;
    first_dat = '0; first_addr = '0;
    forever begin
      @(negedge clk);
      bus.dp_row_ready = 1'b0;
      bus.dp_res_valid = 1'b0;
      bus.dp_done      = 1'b0;
      if (reset_b !== 1'b1) begin
        mode = 0; seen = 1'b0; stall = 0;
      end else begin
        if (bus.dp_start === 1'b1) begin
          start_cnt++;
          mdim = int'(bus.dp_dim);
          dim_log.push_back(mdim);
          mrows = 0; mode = 1; seen = 1'b0; stall = 0;
        end
        if (mode == 1 && bus.dp_row_valid === 1'b1) begin
          if (!seen) begin
            seen = 1'b1;
            first_dat  = bus.dp_row_data;
            first_addr = bus.dut_sram_read_address;
          end else begin
            check_eq("row_data_stable", 32'(bus.dp_row_data), 32'(first_dat));
            check_eq("rd_addr_stable", 32'(bus.dut_sram_read_address), 32'(first_addr));
          end
          if (stall < stall_cfg) begin
            stall++;
          end else begin
            bus.dp_row_ready = 1'b1;
            rx_q.push_back(first_dat);
            rx_addr_q.push_back(first_addr);
            seen = 1'b0; stall = 0; mrows++;
            if (mrows == mdim) begin
              mode = 2;
              left = (res_n_ovr != 0) ? res_n_ovr : (mdim - 2) * (mdim - 2);
            end
          end
        end else if (mode == 2) begin
          bus.dp_res_valid = 1'b1;
          bus.dp_res_data  = 16'h8000 + 16'(res_idx);
          res_idx++;
          left--;
          if (left == 0) begin
            bus.dp_done = 1'b1;
            mode = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    wr_q.delete(); rx_q.delete(); rx_addr_q.delete(); dim_log.delete();
    start_cnt = 0; res_idx = 0;
  endtask

  // Pulse dut_run for 'hold' cycles, then count cycles with busy high.
  task automatic do_run(input int hold, input int budget, output int busy_n);
    @(negedge clk);
    bus.dut_run = 1'b1;
    busy_n = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (k + 1 >= hold) bus.dut_run = 1'b0;
      if (bus.dut_busy !== 1'b1) break;
      busy_n++;
    end
    bus.dut_run = 1'b0;
    fall_cyc = cyc;
    check_eq("run_completes", 32'(busy_n < budget), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int n, input bit consec);
    int bad_a, bad_d, bad_c;
    bad_a = 0; bad_d = 0; bad_c = 0;
    check_eq({tag, "_wr_count"}, 32'(wr_q.size()), 32'(n));
    foreach (wr_q[i]) begin
      if (wr_q[i].a !== ADDR_W'(i)) bad_a++;
      if (wr_q[i].d !== (16'h8000 + DATA_W'(i))) bad_d++;
      if (consec && i > 0) begin
        if (wr_q[i].c != wr_q[i-1].c + 1) bad_c++;
      end
    end
    check_eq({tag, "_wr_addr_bad"}, 32'(bad_a), 32'd0);
    check_eq({tag, "_wr_data_bad"}, 32'(bad_d), 32'd0);
    if (consec) check_eq({tag, "_wr_gap_bad"}, 32'(bad_c), 32'd0);
  endtask

  task automatic load_4x4();
    imem[0] = 16'd4;
    imem[1] = 16'h1111; imem[2] = 16'h2222; imem[3] = 16'h3333; imem[4] = 16'h4444;
    imem[5] = TERM_WORD;
  endtask

  task automatic check_4x4_rows(input string tag);
    check_eq({tag, "_rows"}, 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      check_eq({tag, "_row_data"}, 32'(rx_q[i]), 32'(16'h1111 * (i + 1)));
      check_eq({tag, "_row_addr"}, 32'(rx_addr_q[i]), 32'(i + 1));
    end
  endtask

  initial begin : main
    int bn;
    int bad;
    bus.dut_run = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      imem[i] = '0;
      wmem[i] = '0;
    end
    reset_b = 1'b1;
    #1 reset_b = 1'b0;
    #1;
    check_eq("rst_busy", 32'(bus.dut_busy), 32'd0);
    check_eq("rst_we", 32'(bus.dut_sram_write_enable), 32'd0);
    check_eq("rst_start", 32'(bus.dp_start), 32'd0);
    check_eq("rst_row_valid", 32'(bus.dp_row_valid), 32'd0);
    check_eq("rst_rd_addr", 32'(bus.dut_sram_read_address), 32'd0);
    check_eq("rst_kernel", 32'(bus.dp_kernel), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;

    // Single 4x4 matrix, ready always high.
    load_4x4();
    wmem[0] = 16'hFF3C;
    clear_logs();
    do_run(1, 200, bn);
    check_4x4_rows("m4");
    check_writes("m4", 4, 1'b1);
    check_eq("m4_kernel", 32'(bus.dp_kernel), 32'h13C);
    check_eq("m4_starts", 32'(start_cnt), 32'd1);
    check_eq("m4_dim", 32'(dim_log.size() > 0 ? dim_log[0] : -1), 32'd4);
    if (wr_q.size() > 0) check_eq("m4_busy_after_write", 32'(fall_cyc > wr_q[wr_q.size()-1].c), 32'd1);

    // Two matrices: 3x3 then 16x16; kernel source changed mid-run.
    imem[0] = 16'd3;
    for (int i = 1; i <= 3; i++) imem[i] = 16'hA000 + 16'(i);
    imem[4] = 16'd16;
    for (int i = 5; i <= 20; i++) imem[i] = 16'hB000 + 16'(i);
    imem[21] = TERM_WORD;
    wmem[0] = 16'h0155;
    clear_logs();
    fork
      do_run(1, 2000, bn);
      begin
        repeat (10) @(negedge clk);
        wmem[0] = 16'h00AA;
      end
    join
    check_eq("m2_starts", 32'(start_cnt), 32'd2);
    check_eq("m2_rows", 32'(rx_q.size()), 32'd19);
    if (rx_q.size() == 19) begin
      bad = 0;
      for (int i = 0; i < 3; i++) if (rx_q[i] !== 16'hA000 + 16'(i + 1)) bad++;
      for (int i = 3; i < 19; i++) if (rx_q[i] !== 16'hB000 + 16'(i + 2)) bad++;
      check_eq("m2_row_data_bad", 32'(bad), 32'd0);
      check_eq("m2_hdr2_next_addr", 32'(rx_addr_q[3]), 32'd5);
      check_eq("m2_last_addr", 32'(rx_addr_q[18]), 32'd20);
    end
    if (dim_log.size() == 2) check_eq("m2_dim2", 32'(dim_log[1]), 32'd16);
    check_writes("m2", 197, 1'b0);
    check_eq("m2_kernel_once", 32'(bus.dp_kernel), 32'h155);

    // Backpressure: 5 stall cycles per row.
    load_4x4();
    stall_cfg = 5;
    clear_logs();
    do_run(1, 400, bn);
    stall_cfg = 0;
    check_4x4_rows("bp");
    check_writes("bp", 4, 1'b1);

    // Illegal headers at address 0 end the run at once; run held high is ignored.
    imem[0] = 16'd2;
    clear_logs();
    do_run(3, 100, bn);
    check_eq("h2_busy_cycles", 32'(bn), 32'd4);
    check_eq("h2_starts", 32'(start_cnt), 32'd0);
    check_eq("h2_writes", 32'(wr_q.size()), 32'd0);
    imem[0] = 16'd17;
    clear_logs();
    do_run(1, 100, bn);
    check_eq("h17_busy_cycles", 32'(bn), 32'd4);
    check_eq("h17_starts", 32'(start_cnt), 32'd0);
    check_eq("h17_writes", 32'(wr_q.size()), 32'd0);

    // Reset during ROW_HOLD, then a clean rerun from address 0.
    load_4x4();
    wmem[0] = 16'hFF3C;
    clear_logs();
    @(negedge clk);
    bus.dut_run = 1'b1;
    @(negedge clk);
    bus.dut_run = 1'b0;
    bn = 0;
    while (bus.dp_row_valid !== 1'b1 && bn < 50) begin
      @(negedge clk);
      bn++;
    end
    check_eq("rr_reach_row_hold", 32'(bn < 50), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    check_eq("rr_busy", 32'(bus.dut_busy), 32'd0);
    check_eq("rr_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("rr_row_valid", 32'(bus.dp_row_valid), 32'd0);
    check_eq("rr_row_data", 32'(bus.dp_row_data), 32'd0);
    check_eq("rr_rd_addr", 32'(bus.dut_sram_read_address), 32'd0);
    check_eq("rr_kernel", 32'(bus.dp_kernel), 32'd0);
    check_eq("rr_dim", 32'(bus.dp_dim), 32'd0);
    check_eq("rr_we", 32'(bus.dut_sram_write_enable), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_b = 1'b1;
    clear_logs();
    do_run(1, 200, bn);
    check_4x4_rows("rr");
    check_writes("rr", 4, 1'b1);

    // Burst of 8 back-to-back results.
    imem[0] = 16'd3;
    for (int i = 1; i <= 3; i++) imem[i] = 16'hC000 + 16'(i);
    imem[4] = TERM_WORD;
    res_n_ovr = 8;
    clear_logs();
    do_run(1, 200, bn);
    check_writes("burst", 8, 1'b1);
    check_eq("burst_starts", 32'(start_cnt), 32'd1);

    // 4100 results: output address wraps 4095 -> 0.
    res_n_ovr = 4100;
    clear_logs();
    do_run(1, 6000, bn);
    res_n_ovr = 0;
    check_writes("wrap", 4100, 1'b1);
    if (wr_q.size() == 4100) begin
      check_eq("wrap_addr_4095", 32'(wr_q[4095].a), 32'd4095);
      check_eq("wrap_addr_0", 32'(wr_q[4096].a), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_run_sequencer.md
Name: conv_run_sequencer

Overview:
- Top-level control sequencer for the binary convolution engine.
- Owns the `dut_run`/`dut_busy` handshake and the weight and input SRAM read ports.
- Walks the input SRAM matrix-by-matrix and streams rows to the convolution datapath.
- Writes every datapath result word sequentially into the output SRAM, starting at address 0.

Parameters:
- ADDR_W, 12, SRAM address width (input, weight, output).
- DATA_W, 16, SRAM word width; one word holds one matrix row.
- TERM_WORD, 16'h00FF, header value that ends a run.
- MIN_DIM, 3, smallest legal matrix dimension.
- MAX_DIM, 16, largest legal matrix dimension.

Ports:
- clk, in, 1, system clock.
- reset_b, in, 1, asynchronous active-low reset.
- dut_run, in, 1, run request; sampled only in IDLE.
- dut_busy, out, 1, high from run acceptance until the final output write completes.
- dut_sram_read_address, out, ADDR_W, input SRAM read address; data returns 1 cycle later.
- sram_dut_read_data, in, DATA_W, input SRAM read data.
- dut_wmem_read_address, out, ADDR_W, weight SRAM read address.
- wmem_dut_read_data, in, DATA_W, weight SRAM read data.
- dut_sram_write_enable, out, 1, output SRAM write strobe.
- dut_sram_write_address, out, ADDR_W, output SRAM write address.
- dut_sram_write_data, out, DATA_W, output SRAM write data.
- dp_start, out, 1, one-cycle pulse beginning a matrix.
- dp_dim, out, 5, current matrix dimension; stable from dp_start to dp_done.
- dp_kernel, out, 9, 3x3 binary kernel (weight word 0, bits [8:0]).
- dp_row_valid, out, 1, dp_row_data is valid.
- dp_row_data, out, DATA_W, current matrix row.
- dp_row_ready, in, 1, datapath accepts the row.
- dp_res_valid, in, 1, result word valid.
- dp_res_data, in, DATA_W, result word.
- dp_done, in, 1, pulse: datapath has emitted the last result of the current matrix.

Behaviour:
- Reset, asynchronous, any state: go to IDLE. All outputs 0. Address counters in_ptr and out_ptr cleared to 0.
- IDLE: when dut_run=1, next cycle dut_busy=1, dut_wmem_read_address=0, go to WLOAD. A dut_run held high while busy is ignored.
- WLOAD, 1 cycle: latch wmem_dut_read_data[8:0] into dp_kernel. Set in_ptr=0. Go to HDR_REQ.
- HDR_REQ: drive dut_sram_read_address=in_ptr, go to HDR_CHK.
- HDR_CHK: examine sram_dut_read_data.
  - If it equals TERM_WORD, or lies outside MIN_DIM..MAX_DIM: go to DRAIN. An out-of-range header is a terminator; no error flag is raised.
  - Otherwise: latch dp_dim, pulse dp_start, set row_cnt=0, in_ptr=in_ptr+1, go to ROW_REQ.
- ROW_REQ: drive address in_ptr, go to ROW_HOLD.
- ROW_HOLD:
  - Register read data into dp_row_data and assert dp_row_valid, holding both until dp_row_ready=1.
  - On acceptance: deassert dp_row_valid, in_ptr+1, row_cnt+1.
  - If row_cnt reaches dp_dim, go to WAIT_DP; otherwise go to ROW_REQ.
  - Maximum throughput is one row per 2 cycles.
- WAIT_DP: on dp_done, go to HDR_REQ; in_ptr now points at the next header.
- DRAIN: wait until no write is pending, then go to IDLE with dut_busy=0 in the same cycle.
- Result path runs in every state except IDLE:
  - A dp_res_valid=1 in cycle t gives, in cycle t+1: write_enable=1, write_address=out_ptr, write_data=dp_res_data. out_ptr increments.
  - Back-to-back results are written every cycle.
- dp_done and dp_res_valid may coincide; the result is still written.
- in_ptr and out_ptr wrap from 4095 to 0 silently.
- out_ptr resets to 0 only on reset or at run acceptance, so each run overwrites from address 0.
- A dp_res_valid while in IDLE is dropped.

Decomposition:
- Shared package conv_pkg holds: the state enum (IDLE, WLOAD, HDR_REQ, HDR_CHK, ROW_REQ, ROW_HOLD, WAIT_DP, DRAIN), TERM_WORD, MIN_DIM, MAX_DIM, and the SRAM width constants.
- One natural sub-module: conv_result_writer. It holds out_ptr and the registered write port, so it can be verified alone.

Test Plan:
- Reset mid-run: assert reset_b=0 during ROW_HOLD -> all outputs 0 and state IDLE immediately, with no clock edge needed; the next run writes from address 0.
- Single 4x4 matrix, words {4, r0..r3, 0x00FF}, dp_row_ready tied 1, datapath model returns 4 results -> rows delivered in order, addresses 1..4 read, outputs at 0..3, busy falls after the write to address 3.
- Two matrices, dims 3 then 16, followed by the terminator -> second header read from address 4. Outputs contiguous 0..(1+196-1)=0..196 using model counts (1 and 196). Kernel latched exactly once.
- Backpressure: dp_row_ready low 5 cycles per row -> dp_row_data stable while valid, no row skipped or duplicated, in_ptr advances only on handshake.
- Header 2, or header 17, at address 0 -> no dp_start, no writes, dut_busy high for about 4 cycles then low.
- Burst of 8 consecutive dp_res_valid with dp_done on the last -> 8 consecutive write cycles. Preset out_ptr near 4095 -> address wraps to 0.
